// File: rtl/apb4_mmio_bridge.sv
// APB4 completer bridging onto a simple MMIO requester port, with address-window
// decode, one-wait-state writes and handshaked reads bounded by a timeout counter.
`timescale 1ns/1ps
module apb4_mmio_bridge #(
   parameter int          A_WIDTH   = 32,
   parameter int          D_WIDTH   = 32,
   parameter int unsigned ADDR_BASE = 0,
   parameter int unsigned ADDR_SIZE = 0,
   parameter int unsigned TIMEOUT   = 256
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   s_apb_psel,
   input  logic                   s_apb_penable,
   input  logic                   s_apb_pwrite,
   input  logic [A_WIDTH-1:0]     s_apb_paddr,
   input  logic [D_WIDTH-1:0]     s_apb_pwdata,
   input  logic [D_WIDTH/8-1:0]   s_apb_pstrb,
   output logic [D_WIDTH-1:0]     s_apb_prdata,
   output logic                   s_apb_pready,
   output logic                   s_apb_pslverr,
   output logic                   m_mmio_wr_en,
   output logic [A_WIDTH-1:0]     m_mmio_wr_addr,
   output logic [D_WIDTH-1:0]     m_mmio_wr_data,
   output logic [D_WIDTH/8-1:0]   m_mmio_wr_byteen,
   output logic                   m_mmio_rd_en,
   output logic [A_WIDTH-1:0]     m_mmio_rd_addr,
   input  logic [D_WIDTH-1:0]     m_mmio_rd_data,
   input  logic                   m_mmio_rd_valid
);

   localparam int S_WIDTH = D_WIDTH / 8;
   localparam int C_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [C_WIDTH-1:0] CNT_LAST = (TIMEOUT > 0) ? C_WIDTH'(TIMEOUT - 1) : '0;
   localparam logic [A_WIDTH-1:0] BASE = A_WIDTH'(ADDR_BASE);
   localparam logic [A_WIDTH-1:0] SIZE = A_WIDTH'(ADDR_SIZE);
   localparam bit HAS_TIMEOUT = (TIMEOUT != 0);
   localparam bit NO_DECODE   = (ADDR_SIZE == 0);

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD,
      RD_WAIT,
      ERR,
      RESP
   } state_t;

   state_t               state_reg;
   logic [C_WIDTH-1:0]   cnt_reg;
   logic [A_WIDTH-1:0]   addr_reg;
   logic [D_WIDTH-1:0]   wdata_reg;
   logic [S_WIDTH-1:0]   byteen_reg;
   logic                 wr_en_reg;
   logic                 rd_en_reg;
   logic [D_WIDTH-1:0]   prdata_reg;
   logic                 pready_reg;
   logic                 pslverr_reg;

   logic [A_WIDTH-1:0]   offset;
   logic                 in_window;

   // The subtraction wraps for addresses below the base, so the lower-bound test is explicit.
   always_comb begin
      offset    = s_apb_paddr - BASE;
      in_window = NO_DECODE || ((s_apb_paddr >= BASE) && (offset < SIZE));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         byteen_reg  <= '0;
         wr_en_reg   <= 1'b0;
         rd_en_reg   <= 1'b0;
         prdata_reg  <= '0;
         pready_reg  <= 1'b0;
         pslverr_reg <= 1'b0;
      end else if (state_reg != IDLE && !s_apb_psel) begin
         // Requester walked away mid-transfer: drop everything, keep the last read data.
         wr_en_reg   <= 1'b0;
         rd_en_reg   <= 1'b0;
         pready_reg  <= 1'b0;
         pslverr_reg <= 1'b0;
         state_reg   <= IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (s_apb_psel && !s_apb_penable) begin
                  addr_reg   <= offset;
                  wdata_reg  <= s_apb_pwdata;
                  byteen_reg <= s_apb_pstrb;
                  if (!in_window) begin
                     state_reg <= ERR;
                  end else if (s_apb_pwrite) begin
                     wr_en_reg <= |s_apb_pstrb;
                     state_reg <= WR;
                  end else begin
                     rd_en_reg <= 1'b1;
                     state_reg <= RD;
                  end
               end
            end
            WR: begin
               wr_en_reg   <= 1'b0;
               pready_reg  <= 1'b1;
               pslverr_reg <= 1'b0;
               state_reg   <= RESP;
            end
            RD: begin
               rd_en_reg <= 1'b0;
               if (m_mmio_rd_valid) begin
                  prdata_reg  <= m_mmio_rd_data;
                  pslverr_reg <= 1'b0;
                  pready_reg  <= 1'b1;
                  state_reg   <= RESP;
               end else begin
                  cnt_reg   <= '0;
                  state_reg <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               cnt_reg <= cnt_reg + C_WIDTH'(1);
               // Data arriving on the last allowed cycle still beats the timeout.
               if (m_mmio_rd_valid) begin
                  prdata_reg  <= m_mmio_rd_data;
                  pslverr_reg <= 1'b0;
                  pready_reg  <= 1'b1;
                  state_reg   <= RESP;
               end else if (HAS_TIMEOUT && cnt_reg == CNT_LAST) begin
                  prdata_reg  <= '0;
                  pslverr_reg <= 1'b1;
                  pready_reg  <= 1'b1;
                  state_reg   <= RESP;
               end
            end
            ERR: begin
               prdata_reg  <= '0;
               pslverr_reg <= 1'b1;
               pready_reg  <= 1'b1;
               state_reg   <= RESP;
            end
            RESP: begin
               pready_reg  <= 1'b0;
               pslverr_reg <= 1'b0;
               state_reg   <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign s_apb_prdata     = prdata_reg;
   assign s_apb_pready     = pready_reg;
   assign s_apb_pslverr    = pslverr_reg;
   assign m_mmio_wr_en     = wr_en_reg;
   assign m_mmio_wr_addr   = addr_reg;
   assign m_mmio_wr_data   = wdata_reg;
   assign m_mmio_wr_byteen = byteen_reg;
   assign m_mmio_rd_en     = rd_en_reg;
   assign m_mmio_rd_addr   = addr_reg;

endmodule

// File: tb/tb_apb4_mmio_bridge.sv
// Directed bench for apb4_mmio_bridge: window 0x1000..0x10FF, read timeout 16.
// Expected responses and MMIO strobes go into queues; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_apb4_mmio_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic        wr_en, rd_en;
   logic [31:0] wr_addr, wr_data, rd_addr;
   logic [3:0]  byteen;
   logic        rsp_valid, stale_valid;
   logic [31:0] rsp_data;

   always #5 clk = ~clk;

   apb4_mmio_bridge #(
      .A_WIDTH(32), .D_WIDTH(32), .ADDR_BASE(32'h1000), .ADDR_SIZE(32'h100), .TIMEOUT(16)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .s_apb_psel(psel), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
      .s_apb_paddr(paddr), .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb),
      .s_apb_prdata(prdata), .s_apb_pready(pready), .s_apb_pslverr(pslverr),
      .m_mmio_wr_en(wr_en), .m_mmio_wr_addr(wr_addr), .m_mmio_wr_data(wr_data),
      .m_mmio_wr_byteen(byteen), .m_mmio_rd_en(rd_en), .m_mmio_rd_addr(rd_addr),
      .m_mmio_rd_data(stale_valid ? 32'hCAFEF00D : rsp_data),
      .m_mmio_rd_valid(rsp_valid | stale_valid)
   );

   typedef struct { int cyc; logic err; logic [31:0] data; } apb_exp_t;
   typedef struct { int cyc; bit is_wr; logic [31:0] addr; logic [31:0] data; logic [3:0] be; } mmio_exp_t;

   apb_exp_t  apb_q[$];
   mmio_exp_t mmio_q[$];
   apb_exp_t  ae;
   mmio_exp_t me;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rsp_delay = -1;
   logic [31:0] rsp_word = 32'h0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h want=%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // MMIO read responder: answers rd_en after rsp_delay cycles (0 = same cycle, -1 = never).
   initial begin
      rsp_valid = 1'b0;
      rsp_data  = 32'hBAD0BAD0;
      forever begin
         @(negedge clk);
         if (rd_en && rsp_delay >= 0) begin
            if (rsp_delay > 0) begin
               repeat (rsp_delay) @(posedge clk);
               #1;
            end
            rsp_valid = 1'b1;
            rsp_data  = rsp_word;
            @(posedge clk);
            #1;
            rsp_valid = 1'b0;
            rsp_data  = 32'hBAD0BAD0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (pready) begin
            if (apb_q.size() == 0) check("unexpected_pready", 64'(pready), 64'h0);
            else begin
               ae = apb_q.pop_front();
               $display("resp cyc=%0d pslverr=%0b prdata=%h", cyc, pslverr, prdata);
               check("pready_cycle", 64'(cyc), 64'(ae.cyc));
               check("pslverr", 64'(pslverr), 64'(ae.err));
               check("prdata", 64'(prdata), 64'(ae.data));
            end
         end
         if (wr_en || rd_en) begin
            check("strobe_exclusive", 64'(wr_en & rd_en), 64'h0);
            if (mmio_q.size() == 0) check("unexpected_strobe", {62'h0, wr_en, rd_en}, 64'h0);
            else begin
               me = mmio_q.pop_front();
               check("strobe_cycle", 64'(cyc), 64'(me.cyc));
               check("strobe_kind", 64'(wr_en), 64'(me.is_wr));
               check("strobe_addr", 64'(me.is_wr ? wr_addr : rd_addr), 64'(me.addr));
               if (me.is_wr) begin
                  check("wr_data", 64'(wr_data), 64'(me.data));
                  check("wr_byteen", 64'(byteen), 64'(me.be));
               end
            end
         end
      end
   end

   // One APB transfer; expectation columns are hand-computed (lat = pready cycle minus setup cycle).
   task automatic run(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int rsp, input logic [31:0] rsp_dat,
                      input bit strobe, input logic [31:0] off, input int lat, input bit err,
                      input logic [31:0] rdata, input int gap);
      int s;
      bit done;
      apb_exp_t  a;
      mmio_exp_t m;
      @(posedge clk);
      #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
      rsp_delay = rsp;
      rsp_word  = rsp_dat;
      s = cyc;
      a.cyc = s + lat; a.err = err; a.data = rdata;
      apb_q.push_back(a);
      if (strobe) begin
         m.cyc = s + 1; m.is_wr = wr; m.addr = off; m.data = wdata; m.be = strb;
         mmio_q.push_back(m);
      end
      $display("xfer %s addr=%h wdata=%h strb=%h setup_cyc=%0d", wr ? "WR" : "RD", addr, wdata, strb, s);
      @(posedge clk);
      #1;
      penable = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         done = pready;
      end
      if (!done) check("pready_wait", 64'h0, 64'h1);
      repeat (gap) begin
         @(posedge clk);
         #1;
         psel = 1'b0; penable = 1'b0;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctrl"}, {56'h0, pready, pslverr, wr_en, rd_en, byteen}, 64'h0);
      check({tag, "_prdata"}, 64'(prdata), 64'h0);
      check({tag, "_addr"}, {wr_addr, rd_addr}, 64'h0);
      check({tag, "_wdata"}, 64'(wr_data), 64'h0);
   endtask

   // Read left hanging in RD_WAIT (nobody answers); strobe is expected, response is not.
   task automatic start_hung_read(input logic [31:0] addr, input logic [31:0] off);
      mmio_exp_t m;
      @(posedge clk);
      #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr; pwdata = 32'h77777777; pstrb = 4'hF;
      rsp_delay = -1;
      m.cyc = cyc + 1; m.is_wr = 1'b0; m.addr = off; m.data = 32'h0; m.be = 4'h0;
      mmio_q.push_back(m);
      $display("xfer RD addr=%h (left unanswered) setup_cyc=%0d", addr, cyc);
      @(posedge clk);
      #1;
      penable = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
      stale_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      //   wr  addr          wdata         strb rsp  rsp_data      strobe off     lat err rdata        gap
      run(1, 32'h0000_1010, 32'hDEADBEEF, 4'h3, -1, 32'h0,         1, 32'h10, 2,  0, 32'h0,        1);
      run(0, 32'h0000_1020, 32'h0,        4'h0,  3, 32'h12345678,  1, 32'h20, 5,  0, 32'h12345678, 0);
      run(1, 32'h0000_1030, 32'hA5A5A5A5, 4'h0, -1, 32'h0,         0, 32'h0,  2,  0, 32'h12345678, 0);
      run(0, 32'h0000_1040, 32'h0,        4'h0, -1, 32'h0,         1, 32'h40, 18, 1, 32'h0,        1);

      // Late data after the timeout must be ignored.
      repeat (3) @(posedge clk);
      #1;
      stale_valid = 1'b1;
      $display("stale rd_valid pulse cyc=%0d", cyc);
      @(posedge clk);
      #1;
      stale_valid = 1'b0;
      check("stale_prdata", 64'(prdata), 64'h0);

      run(0, 32'h0000_1044, 32'h0,        4'h0,  0, 32'h0F0F0F0F,  1, 32'h44, 2,  0, 32'h0F0F0F0F, 0);
      run(0, 32'h0000_1100, 32'h0,        4'h0,  0, 32'h99999999,  0, 32'h0,  2,  1, 32'h0,        0);
      run(1, 32'h0000_1100, 32'hCCCCCCCC, 4'hF, -1, 32'h0,         0, 32'h0,  2,  1, 32'h0,        0);
      run(1, 32'h0000_0FFC, 32'h11111111, 4'hF, -1, 32'h0,         0, 32'h0,  2,  1, 32'h0,        1);
      run(1, 32'h0000_10FC, 32'h0BADF00D, 4'hF, -1, 32'h0,         1, 32'hFC, 2,  0, 32'h0,        0);
      run(0, 32'h0000_10FC, 32'h0,        4'h0,  1, 32'h55AA1234,  1, 32'hFC, 3,  0, 32'h55AA1234, 1);
      run(1, 32'h0000_1004, 32'h11223344, 4'hC, -1, 32'h0,         1, 32'h4,  2,  0, 32'h55AA1234, 0);
      run(0, 32'h0000_1008, 32'h0,        4'h0,  0, 32'h89ABCDEF,  1, 32'h8,  2,  0, 32'h89ABCDEF, 0);
      run(0, 32'h0000_10F8, 32'h0,        4'h0, 16, 32'hFEEDFACE,  1, 32'hF8, 18, 0, 32'hFEEDFACE, 1);

      // psel dropped while waiting for read data: no response may follow.
      start_hung_read(32'h0000_1050, 32'h50);
      repeat (3) @(posedge clk);
      #1;
      psel = 1'b0; penable = 1'b0;
      $display("abort psel cyc=%0d", cyc);
      repeat (20) @(posedge clk);
      #1;
      check("abort_pready", 64'(pready), 64'h0);
      check("abort_prdata_held", 64'(prdata), 64'hFEEDFACE);

      // Asynchronous reset in RD_WAIT clears every output without waiting for an edge.
      start_hung_read(32'h0000_1060, 32'h60);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      $display("reset asserted in RD_WAIT cyc=%0d", cyc);
      check_all_zero("midreset");
      @(posedge clk);
      #1;
      psel = 1'b0; penable = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      run(1, 32'h0000_1000, 32'h13579BDF, 4'hF, -1, 32'h0,         1, 32'h0,  2,  0, 32'h0,        1);
      run(0, 32'h0000_1000, 32'h0,        4'h0,  2, 32'h2468ACE0,  1, 32'h0,  4,  0, 32'h2468ACE0, 0);
      run(0, 32'h0000_10F0, 32'h0,        4'h0, 17, 32'h0DDBA11E,  1, 32'hF0, 18, 1, 32'h0,        1);

      repeat (5) @(posedge clk);
      #1;
      check("apb_queue_drained", 64'(apb_q.size()), 64'h0);
      check("mmio_queue_drained", 64'(mmio_q.size()), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
